// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch constants: RV32I branch funct3 encodings and the 2-bit predictor
// counter encoding, with the saturating counter step used by the BHT.
package branch_resolve_unit_pkg;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_f3_e;

   localparam logic [1:0] BHT_CTR_MIN   = 2'b00;
   localparam logic [1:0] BHT_CTR_RESET = 2'b01;
   localparam logic [1:0] BHT_CTR_MAX   = 2'b11;

   function automatic logic [1:0] bht_ctr_next(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == BHT_CTR_MAX) ? ctr : ctr + 2'd1;
      end
      return (ctr == BHT_CTR_MIN) ? ctr : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bht_2bit.sv
// 2-bit saturating branch history table: combinational read, one registered update per cycle.
// Read returns the pre-update value when read and update hit the same entry in one cycle.
module bht_2bit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [IW-1:0] rd_idx,
   output logic          rd_taken,
   input  logic          upd_en,
   input  logic [IW-1:0] upd_idx,
   input  logic          upd_taken
);

   logic [1:0] ctr [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ctr[i] <= BHT_CTR_RESET;
      end else if (upd_en) begin
         ctr[upd_idx] <= bht_ctr_next(ctr[upd_idx], upd_taken);
      end
   end

   assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve: compare, target, mispredict flag and BHT training; one-cycle latency.
// Single output register; in_ready = flush || !out_valid || out_ready, so it drains and refills each cycle.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      f3,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic            out_mispredict,
   output logic            out_illegal,
   input  logic            flush,
   output logic [31:0]     br_count,
   output logic [31:0]     mispred_count
);

   localparam int IW = $clog2(BHT_DEPTH);

   logic          taken_c;
   logic          illegal_c;
   logic          accept;
   logic          out_hs;
   logic          upd_en;
   logic [IW-1:0] out_idx;
   logic          unused_pc_bits;

   always_comb begin
      taken_c   = 1'b0;
      illegal_c = 1'b0;
      case (f3)
         F3_BEQ:  taken_c = (rs1 == rs2);
         F3_BNE:  taken_c = (rs1 != rs2);
         F3_BLT:  taken_c = ($signed(rs1) <  $signed(rs2));
         F3_BGE:  taken_c = ($signed(rs1) >= $signed(rs2));
         F3_BLTU: taken_c = (rs1 <  rs2);
         F3_BGEU: taken_c = (rs1 >= rs2);
         default: illegal_c = 1'b1;
      endcase
   end

   // Flush always frees the slot, but whatever is presented alongside it is dropped.
   assign in_ready = flush || !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign out_hs   = out_valid && out_ready;
   assign upd_en   = out_hs && !out_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_taken      <= 1'b0;
         out_target     <= '0;
         out_mispredict <= 1'b0;
         out_illegal    <= 1'b0;
         out_idx        <= '0;
      end else if (flush) begin
         out_valid      <= 1'b0;
         out_taken      <= 1'b0;
         out_target     <= '0;
         out_mispredict <= 1'b0;
         out_illegal    <= 1'b0;
         out_idx        <= '0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         out_taken      <= taken_c;
         out_target     <= pc + imm;
         out_mispredict <= !illegal_c && (taken_c ^ pred_taken);
         out_illegal    <= illegal_c;
         out_idx        <= pc[IW+1:2];
      end else if (out_hs) begin
         out_valid      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (upd_en) begin
         br_count <= br_count + 32'd1;
         if (out_mispredict) mispred_count <= mispred_count + 32'd1;
      end
   end

   bht_2bit #(.DEPTH(BHT_DEPTH)) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (lookup_pc[IW+1:2]),
      .rd_taken  (lookup_taken),
      .upd_en    (upd_en),
      .upd_idx   (out_idx),
      .upd_taken (out_taken)
   );

   // Word-offset and tag bits of the PCs do not take part in indexing.
   assign unused_pc_bits = ^{pc[XLEN-1:IW+2], pc[1:0], lookup_pc[XLEN-1:IW+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a
// transaction-level reference model (per-index counter array, running counts, held result).
module tb_branch_resolve_unit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [XLEN-1:0] rs1 = '0, rs2 = '0, pc = '0, imm = '0, lookup_pc = '0;
   logic [2:0]      f3 = 3'b000;
   logic            pred_taken = 1'b0;
   logic            lookup_taken;
   logic            out_valid, out_taken, out_mispredict, out_illegal;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] out_target;
   logic            flush = 1'b0;
   logic [31:0]     br_count, mispred_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          mbht[DEPTH];
   logic [31:0] m_br, m_mis;
   logic        e_vld, e_taken, e_mis, e_ill;
   logic [31:0] e_tgt;
   int          e_idx;

   branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rs1(rs1), .rs2(rs2), .f3(f3), .pc(pc), .imm(imm), .pred_taken(pred_taken),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_target(out_target), .out_mispredict(out_mispredict), .out_illegal(out_illegal),
      .flush(flush), .br_count(br_count), .mispred_count(mispred_count)
   );

   always #5 clk = ~clk;

   function automatic logic ref_illegal(input logic [2:0] f);
      return (f == 3'd2) || (f == 3'd3);
   endfunction

   function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) <  $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a <  b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int ref_idx(input logic [31:0] p);
      return int'(p / 4) % DEPTH;
   endfunction

   task automatic m_reset;
      for (int i = 0; i < DEPTH; i++) mbht[i] = 1;
      m_br = 0; m_mis = 0;
      e_vld = 0; e_taken = 0; e_mis = 0; e_ill = 0; e_tgt = 0; e_idx = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven, then step the DUT.
   task automatic tick;
      logic hs, acc;
      hs  = e_vld && out_ready;
      acc = in_valid && !flush && (!e_vld || out_ready);
      if (hs && !e_ill) begin
         m_br = m_br + 1;
         if (e_mis) m_mis = m_mis + 1;
         if (e_taken) mbht[e_idx] = (mbht[e_idx] == 3) ? 3 : mbht[e_idx] + 1;
         else         mbht[e_idx] = (mbht[e_idx] == 0) ? 0 : mbht[e_idx] - 1;
      end
      if (flush) e_vld = 0;
      else if (acc) begin
         e_vld   = 1;
         e_ill   = ref_illegal(f3);
         e_taken = e_ill ? 1'b0 : ref_taken(f3, rs1, rs2);
         e_mis   = e_ill ? 1'b0 : (e_taken ^ pred_taken);
         e_tgt   = pc + imm;
         e_idx   = ref_idx(pc);
      end else if (hs) e_vld = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i, input logic pt);
      in_valid = 1; f3 = f; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt;
   endtask

   task automatic do_reset;
      in_valid = 0; flush = 0;
      rst_n = 0;
      m_reset();
      #3;
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset;
      lookup_pc = 32'h100;
      #1 rst_n = 0;
      m_reset();
      #2;
      checks++;
      if ({out_valid, out_taken, out_mispredict, out_illegal} !== 4'b0 || out_target !== 32'h0) begin
         errors++; $display("FAIL reset_outputs got v=%b t=%b m=%b i=%b tgt=%h exp all 0",
                            out_valid, out_taken, out_mispredict, out_illegal, out_target);
      end
      checks++;
      if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
         errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", br_count, mispred_count);
      end
      checks++;
      if (lookup_taken !== 1'b0) begin
         errors++; $display("FAIL reset_lookup got %b exp 0", lookup_taken);
      end
      rst_n = 1;
      tick();
      tick();
      checks++;
      if (lookup_taken !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset got lk=%b rdy=%b v=%b exp 0 1 0", lookup_taken, in_ready, out_valid);
      end
   endtask

   task automatic test_compare;
      out_ready = 1;
      drive(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8, 1'b0);
      tick();
      checks++;
      if ({out_valid, out_taken, out_mispredict, out_illegal} !== 4'b1110) begin
         errors++; $display("FAIL blt_signed got v/t/m/i=%b exp 1110", {out_valid, out_taken, out_mispredict, out_illegal});
      end
      drive(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h204, 32'h8, 1'b0);
      tick();
      checks++;
      if ({out_valid, out_taken, out_mispredict, out_illegal} !== 4'b1000) begin
         errors++; $display("FAIL bltu_unsigned got v/t/m/i=%b exp 1000", {out_valid, out_taken, out_mispredict, out_illegal});
      end
      drive(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h208, 32'h10, 1'b1);
      tick();
      checks++;
      if ({out_taken, out_mispredict} !== 2'b01 || out_target !== 32'h218) begin
         errors++; $display("FAIL bge_signed got t/m=%b tgt=%h exp 01 00000218", {out_taken, out_mispredict}, out_target);
      end
      drive(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h20C, 32'h10, 1'b1);
      tick();
      checks++;
      if ({out_taken, out_mispredict} !== 2'b10) begin
         errors++; $display("FAIL bgeu_unsigned got t/m=%b exp 10", {out_taken, out_mispredict});
      end
      in_valid = 0;
      tick();
   endtask

   task automatic test_target_wrap;
      out_ready = 1;
      drive(3'b000, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20, 1'b1);
      tick();
      in_valid = 0;
      checks++;
      if (out_target !== 32'h0000_0010 || out_taken !== 1'b1 || out_mispredict !== 1'b0) begin
         errors++; $display("FAIL target_wrap got tgt=%h t=%b m=%b exp 00000010 1 0", out_target, out_taken, out_mispredict);
      end
      tick();
   endtask

   task automatic test_bht_train;
      int up_seq[4] = '{0, 1, 1, 1};
      int dn_seq[4] = '{1, 1, 0, 0};
      do_reset();
      out_ready = 1;
      lookup_pc = 32'h100;
      for (int k = 0; k < 4; k++) begin
         drive(3'b000, 32'(k), 32'(k), 32'h100, 32'h4, 1'b0);
         tick();
         in_valid = 0;
         #1;
         checks++;
         if (lookup_taken !== up_seq[k][0] || lookup_taken !== (mbht[ref_idx(32'h100)] >= 2)) begin
            errors++; $display("FAIL bht_up%0d got %b exp %0d", k, lookup_taken, up_seq[k]);
         end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         drive(3'b001, 32'(k), 32'(k), 32'h100, 32'h4, 1'b0);
         tick();
         in_valid = 0;
         #1;
         checks++;
         if (lookup_taken !== dn_seq[k][0] || lookup_taken !== (mbht[ref_idx(32'h100)] >= 2)) begin
            errors++; $display("FAIL bht_down%0d got %b exp %0d", k, lookup_taken, dn_seq[k]);
         end
         tick();
      end
      checks++;
      if (lookup_taken !== 1'b0 || br_count !== 32'd8 || br_count !== m_br) begin
         errors++; $display("FAIL bht_final got lk=%b br=%0d exp 0 8", lookup_taken, br_count);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] tgt_a;
      out_ready = 1;
      drive(3'b001, 32'h1, 32'h2, 32'h300, 32'h40, 1'b0);
      tick();
      tgt_a = e_tgt;
      out_ready = 0;
      drive(3'b000, 32'h7, 32'h7, 32'h400, 32'h80, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ready%0d got %b exp 0", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_target !== tgt_a || out_taken !== 1'b1 || out_mispredict !== 1'b1) begin
            errors++; $display("FAIL stall_hold%0d got v=%b tgt=%h t=%b m=%b exp 1 %h 1 1",
                               c, out_valid, out_target, out_taken, out_mispredict, tgt_a);
         end
      end
      out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL drain_ready got %b exp 1", in_ready);
      end
      tick();
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || out_target !== 32'h480 || out_target !== e_tgt || out_mispredict !== 1'b1) begin
         errors++; $display("FAIL second_req got v=%b tgt=%h m=%b exp 1 00000480 1", out_valid, out_target, out_mispredict);
      end
      tick();
   endtask

   task automatic test_illegal;
      logic [31:0] br0;
      int          ctr0;
      out_ready = 1;
      for (int k = 2; k < 4; k++) begin
         br0  = m_br;
         ctr0 = mbht[ref_idx(32'h100)];
         drive(3'(k), $urandom, $urandom, 32'h100, $urandom, 1'b1);
         tick();
         in_valid = 0;
         checks++;
         if ({out_valid, out_illegal, out_taken, out_mispredict} !== 4'b1100) begin
            errors++; $display("FAIL illegal_f3_%0d got v/i/t/m=%b exp 1100", k, {out_valid, out_illegal, out_taken, out_mispredict});
         end
         tick();
         checks++;
         if (br_count !== br0 || mbht[ref_idx(32'h100)] != ctr0 || lookup_taken !== (ctr0 >= 2)) begin
            errors++; $display("FAIL illegal_noupd_%0d got br=%0d lk=%b exp %0d %0d", k, br_count, lookup_taken, br0, ctr0 >= 2);
         end
      end
   endtask

   task automatic test_flush;
      logic [31:0] br0, mis0;
      out_ready = 1;
      drive(3'b001, 32'h3, 32'h4, 32'h40, 32'h4, 1'b0);
      tick();
      br0 = m_br; mis0 = m_mis;
      out_ready = 0;
      drive(3'b000, 32'h9, 32'h9, 32'h44, 32'h4, 1'b0);
      flush = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_ready got %b exp 1", in_ready);
      end
      tick();
      flush = 0; in_valid = 0;
      checks++;
      if (out_valid !== 1'b0 || br_count !== br0 || mispred_count !== mis0) begin
         errors++; $display("FAIL flush_clear got v=%b br=%0d mis=%0d exp 0 %0d %0d", out_valid, br_count, mispred_count, br0, mis0);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_discard got v=%b exp 0", out_valid);
      end
      out_ready = 1;
      drive(3'b001, 32'h3, 32'h4, 32'h40, 32'h4, 1'b0);
      tick();
      in_valid = 0; flush = 1;
      tick();
      flush = 0;
      checks++;
      if (out_valid !== 1'b0 || br_count !== br0 + 32'd1 || mispred_count !== mis0 + 32'd1 || br_count !== m_br) begin
         errors++; $display("FAIL flush_hs got v=%b br=%0d mis=%0d exp 0 %0d %0d", out_valid, br_count, mispred_count, br0 + 1, mis0 + 1);
      end
   endtask

   task automatic test_reset_mid_stall;
      out_ready = 1;
      drive(3'b000, 32'h1, 32'h1, 32'h0, 32'h8, 1'b0);
      tick();
      out_ready = 0;
      drive(3'b001, 32'h1, 32'h2, 32'h4, 32'h8, 1'b1);
      tick();
      #2 rst_n = 0;
      m_reset();
      #1;
      checks++;
      if ({out_valid, out_taken, out_mispredict, out_illegal} !== 4'b0 || out_target !== 32'h0
          || br_count !== 32'd0 || mispred_count !== 32'd0) begin
         errors++; $display("FAIL midstall_reset got v=%b t=%b m=%b i=%b tgt=%h br=%0d mis=%0d exp all 0",
                            out_valid, out_taken, out_mispredict, out_illegal, out_target, br_count, mispred_count);
      end
      in_valid = 0;
      #1 rst_n = 1;
      for (int i = 0; i < DEPTH; i++) begin
         lookup_pc = 32'(i * 4);
         #1;
         checks++;
         if (lookup_taken !== 1'b0) begin
            errors++; $display("FAIL bht_reset_idx%0d got %b exp 0", i, lookup_taken);
         end
      end
      tick();
      out_ready = 1;
      drive(3'b000, 32'h2, 32'h2, 32'h0, 32'h4, 1'b1);
      tick();
      in_valid = 0;
      tick();
      lookup_pc = 32'h0;
      #1;
      checks++;
      if (lookup_taken !== 1'b1 || br_count !== 32'd1) begin
         errors++; $display("FAIL bht_reset_weak got lk=%b br=%0d exp 1 1", lookup_taken, br_count);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 600; n++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         f3         = 3'($urandom_range(0, 7));
         rs1        = $urandom;
         rs2        = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
         pc         = $urandom & 32'h0000_03FC;
         imm        = $urandom;
         pred_taken = 1'($urandom_range(0, 1));
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         lookup_pc  = $urandom & 32'h0000_03FC;
         #1;
         checks++;
         if (in_ready !== (flush || !e_vld || out_ready)) begin
            errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, in_ready, flush || !e_vld || out_ready);
         end
         checks++;
         if (lookup_taken !== (mbht[ref_idx(lookup_pc)] >= 2)) begin
            errors++; $display("FAIL rnd_lookup n=%0d got %b exp %b", n, lookup_taken, mbht[ref_idx(lookup_pc)] >= 2);
         end
         tick();
         checks++;
         if (out_valid !== e_vld) begin
            errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, out_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({out_taken, out_mispredict, out_illegal} !== {e_taken, e_mis, e_ill} || out_target !== e_tgt) begin
               errors++; $display("FAIL rnd_result n=%0d got t/m/i=%b tgt=%h exp %b tgt=%h",
                                  n, {out_taken, out_mispredict, out_illegal}, out_target, {e_taken, e_mis, e_ill}, e_tgt);
            end
         end
         checks++;
         if (br_count !== m_br || mispred_count !== m_mis) begin
            errors++; $display("FAIL rnd_counters n=%0d got %0d/%0d exp %0d/%0d", n, br_count, mispred_count, m_br, m_mis);
         end
      end
      in_valid = 0; flush = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_compare();
      test_target_wrap();
      test_bht_train();
      test_back_to_back();
      test_illegal();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
